// File: rtl/uart_cmd_if.sv
// Byte-stream input, decoded-frame handshake and error strobes of the UART command parser.
interface uart_cmd_if;
   logic        rx_dv;
   logic [7:0]  rx_byte;
   logic        frm_valid;
   logic        frm_ready;
   logic [7:0]  frm_cmd;
   logic [15:0] frm_addr;
   logic [15:0] frm_data;
   logic        err_badcmd;
   logic        err_timeout;
   logic        err_overrun;

   // Byte source and frame consumer side
   modport master (
      output rx_dv, rx_byte, frm_ready,
      input  frm_valid, frm_cmd, frm_addr, frm_data,
      input  err_badcmd, err_timeout, err_overrun
   );

   // Parser side
   modport slave (
      input  rx_dv, rx_byte, frm_ready,
      output frm_valid, frm_cmd, frm_addr, frm_data,
      output err_badcmd, err_timeout, err_overrun
   );
endinterface

// File: rtl/uart_cmd_parser.sv
// UART command parser: assembles cmd/addr_l/addr_h/data_l/data_h byte frames into a
// held output register with valid/ready handshake, reporting bad commands, inter-byte
// timeouts and frames dropped because the output register was still occupied.
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT_CLKS = 40000
) (
   input logic       clk40M,
   input logic       nRst,
   uart_cmd_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CLKS);

   typedef enum logic [2:0] {
      S_CMD    = 3'd0,
      S_ADDR_L = 3'd1,
      S_ADDR_H = 3'd2,
      S_DATA_L = 3'd3,
      S_DATA_H = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
   logic [7:0]  cmd, cmd_nxt;
   logic [7:0]  addr_l, addr_l_nxt;
   logic [7:0]  addr_h, addr_h_nxt;
   logic [7:0]  data_l, data_l_nxt;

   logic        hold_valid, hold_valid_nxt;
   logic [7:0]  hold_cmd, hold_cmd_nxt;
   logic [15:0] hold_addr, hold_addr_nxt;
   logic [15:0] hold_data, hold_data_nxt;
   logic        badcmd_p, badcmd_p_nxt;
   logic        timeout_p, timeout_p_nxt;
   logic        overrun_p, overrun_p_nxt;

   logic        legal_cmd_c;
   logic        timeout_c;
   logic        frame_done_c;
   logic        load_ok_c;

   // Decode helpers; a byte arriving in the timeout cycle wins over the timeout
   always_comb begin
      legal_cmd_c  = (bus.rx_byte == 8'hA0) || (bus.rx_byte == 8'hA1) || (bus.rx_byte == 8'hA2);
      timeout_c    = (state != S_CMD) && !bus.rx_dv && (idle_cnt == CNT_MAX);
      frame_done_c = (state == S_DATA_H) && bus.rx_dv;
      load_ok_c    = !hold_valid || bus.frm_ready;
   end

   // State register
   always_ff @(posedge clk40M or negedge nRst) begin
      if (!nRst) begin
         state <= S_CMD;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (timeout_c) begin
         state_nxt = S_CMD;
      end else if (bus.rx_dv) begin
         case (state)
            S_CMD:    state_nxt = legal_cmd_c ? S_ADDR_L : S_CMD;
            S_ADDR_L: state_nxt = S_ADDR_H;
            S_ADDR_H: state_nxt = S_DATA_L;
            S_DATA_L: state_nxt = S_DATA_H;
            S_DATA_H: state_nxt = S_CMD;
            default:  state_nxt = S_CMD;
         endcase
      end
   end

   // Output/datapath next values: byte capture, idle counter, frame register, error pulses
   always_comb begin
      cmd_nxt        = cmd;
      addr_l_nxt     = addr_l;
      addr_h_nxt     = addr_h;
      data_l_nxt     = data_l;
      hold_valid_nxt = hold_valid && !bus.frm_ready;
      hold_cmd_nxt   = hold_cmd;
      hold_addr_nxt  = hold_addr;
      hold_data_nxt  = hold_data;
      badcmd_p_nxt   = 1'b0;
      timeout_p_nxt  = timeout_c;
      overrun_p_nxt  = 1'b0;

      if ((state == S_CMD) || bus.rx_dv || timeout_c) begin
         idle_cnt_nxt = '0;
      end else begin
         idle_cnt_nxt = idle_cnt + CNT_W'(1);
      end

      if (bus.rx_dv) begin
         case (state)
            S_CMD: begin
               if (legal_cmd_c) begin
                  cmd_nxt = bus.rx_byte;
               end else begin
                  badcmd_p_nxt = 1'b1;
               end
            end
            S_ADDR_L: addr_l_nxt = bus.rx_byte;
            S_ADDR_H: addr_h_nxt = bus.rx_byte;
            S_DATA_L: data_l_nxt = bus.rx_byte;
            default: ;
         endcase
      end

      if (frame_done_c) begin
         if (load_ok_c) begin
            hold_valid_nxt = 1'b1;
            hold_cmd_nxt   = cmd;
            hold_addr_nxt  = {addr_h, addr_l};
            hold_data_nxt  = {bus.rx_byte, data_l};
         end else begin
            overrun_p_nxt  = 1'b1;
         end
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk40M or negedge nRst) begin
      if (!nRst) begin
         idle_cnt   <= '0;
         cmd        <= '0;
         addr_l     <= '0;
         addr_h     <= '0;
         data_l     <= '0;
         hold_valid <= 1'b0;
         hold_cmd   <= '0;
         hold_addr  <= '0;
         hold_data  <= '0;
         badcmd_p   <= 1'b0;
         timeout_p  <= 1'b0;
         overrun_p  <= 1'b0;
      end else begin
         idle_cnt   <= idle_cnt_nxt;
         cmd        <= cmd_nxt;
         addr_l     <= addr_l_nxt;
         addr_h     <= addr_h_nxt;
         data_l     <= data_l_nxt;
         hold_valid <= hold_valid_nxt;
         hold_cmd   <= hold_cmd_nxt;
         hold_addr  <= hold_addr_nxt;
         hold_data  <= hold_data_nxt;
         badcmd_p   <= badcmd_p_nxt;
         timeout_p  <= timeout_p_nxt;
         overrun_p  <= overrun_p_nxt;
      end
   end

   assign bus.frm_valid   = hold_valid;
   assign bus.frm_cmd     = hold_cmd;
   assign bus.frm_addr    = hold_addr;
   assign bus.frm_data    = hold_data;
   assign bus.err_badcmd  = badcmd_p;
   assign bus.err_timeout = timeout_p;
   assign bus.err_overrun = overrun_p;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a short inter-byte timeout.
module tb_uart_cmd_parser;

   logic clk40M = 1'b0;
   logic nRst;

   uart_cmd_if bus ();

   uart_cmd_parser #(.TIMEOUT_CLKS(100)) dut (
      .clk40M (clk40M),
      .nRst   (nRst),
      .bus    (bus)
   );

   always #5 clk40M = ~clk40M;

   int n_checks = 0;
   int n_fail   = 0;
   int n_bad    = 0;
   int n_to     = 0;
   int n_ovr    = 0;
   int base;

   // Count error pulses seen on each rising edge
   always @(posedge clk40M) begin
      if (bus.err_badcmd)  n_bad <= n_bad + 1;
      if (bus.err_timeout) n_to  <= n_to + 1;
      if (bus.err_overrun) n_ovr <= n_ovr + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_frame(input string tag, input logic [7:0] c, input logic [15:0] a,
                              input logic [15:0] d);
      check({tag, "_valid"}, 32'(bus.frm_valid), 32'd1);
      check({tag, "_cmd"},   32'(bus.frm_cmd),   32'(c));
      check({tag, "_addr"},  32'(bus.frm_addr),  32'(a));
      check({tag, "_data"},  32'(bus.frm_data),  32'(d));
   endtask

   // Consecutive-cycle strobes, first byte in the most significant used position;
   // frm_ready is raised only during byte index rdy_idx. Returns one cycle after the last strobe.
   task automatic send_seq(input logic [79:0] bytes, input int n, input int rdy_idx);
      for (int i = 0; i < n; i++) begin
         @(negedge clk40M);
         bus.rx_dv     = 1'b1;
         bus.rx_byte   = bytes[8*(n-1-i) +: 8];
         bus.frm_ready = (i == rdy_idx);
      end
      @(negedge clk40M);
      bus.rx_dv     = 1'b0;
      bus.rx_byte   = 8'h00;
      bus.frm_ready = 1'b0;
   endtask

   // Strobes separated by one idle cycle
   task automatic send_spaced(input logic [79:0] bytes, input int n);
      for (int i = 0; i < n; i++) begin
         send_seq(80'(bytes[8*(n-1-i) +: 8]), 1, -1);
      end
   endtask

   task automatic accept();
      bus.frm_ready = 1'b1;
      @(negedge clk40M);
      bus.frm_ready = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},   32'(bus.frm_valid),   32'd0);
      check({tag, "_cmd"},     32'(bus.frm_cmd),     32'd0);
      check({tag, "_addr"},    32'(bus.frm_addr),    32'd0);
      check({tag, "_data"},    32'(bus.frm_data),    32'd0);
      check({tag, "_badcmd"},  32'(bus.err_badcmd),  32'd0);
      check({tag, "_timeout"}, 32'(bus.err_timeout), 32'd0);
      check({tag, "_overrun"}, 32'(bus.err_overrun), 32'd0);
   endtask

   // Run-time guard
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      nRst          = 1'b0;
      bus.rx_dv     = 1'b0;
      bus.rx_byte   = 8'h00;
      bus.frm_ready = 1'b0;
      repeat (3) @(negedge clk40M);
      check_all_zero("reset");
      nRst = 1'b1;
      @(negedge clk40M);

      // Basic frame, held while consumer stalls
      send_spaced(80'hA1_34_12_78_56, 5);
      check_frame("basic", 8'hA1, 16'h1234, 16'h5678);
      repeat (4) @(negedge clk40M);
      check_frame("basic_hold", 8'hA1, 16'h1234, 16'h5678);
      check("basic_acc_pre", 32'(bus.frm_valid), 32'd1);
      accept();
      check("basic_acc_post", 32'(bus.frm_valid), 32'd0);
      check("basic_no_err", 32'(n_bad + n_to + n_ovr), 32'd0);

      // Illegal command byte, then a good frame
      base = n_bad;
      send_seq(80'h55, 1, -1);
      check("badcmd_pulse", 32'(bus.err_badcmd), 32'd1);
      @(negedge clk40M);
      check("badcmd_clear", 32'(bus.err_badcmd), 32'd0);
      check("badcmd_count", 32'(n_bad - base), 32'd1);
      check("badcmd_novalid", 32'(bus.frm_valid), 32'd0);
      send_spaced(80'hA0_01_00_FF_00, 5);
      check_frame("after_bad", 8'hA0, 16'h0001, 16'h00FF);
      accept();

      // Inter-byte timeout: pulse 101 edges after the 01 strobe
      base = n_to;
      send_seq(80'hA2_01, 2, -1);
      repeat (100) @(negedge clk40M);
      check("to_early", 32'(bus.err_timeout), 32'd0);
      @(negedge clk40M);
      check("to_pulse", 32'(bus.err_timeout), 32'd1);
      @(negedge clk40M);
      check("to_clear", 32'(bus.err_timeout), 32'd0);
      check("to_count", 32'(n_to - base), 32'd1);
      check("to_novalid", 32'(bus.frm_valid), 32'd0);
      send_spaced(80'hA1_02_00_03_00, 5);
      check_frame("after_to", 8'hA1, 16'h0002, 16'h0003);
      accept();

      // Byte arriving in the same cycle the counter hits the limit is kept
      base = n_to;
      send_seq(80'hA2_34, 2, -1);
      repeat (99) @(negedge clk40M);
      send_seq(80'h12, 1, -1);
      check("to_race_nopulse", 32'(bus.err_timeout), 32'd0);
      send_spaced(80'h78_56, 2);
      check_frame("to_race", 8'hA2, 16'h1234, 16'h5678);
      check("to_race_count", 32'(n_to - base), 32'd0);
      accept();

      // Back-to-back frames with stalled consumer: second one dropped
      base = n_ovr;
      send_seq(80'hA0_01_00_02_00_A1_03_00_04_00, 10, -1);
      check("ovr_pulse", 32'(bus.err_overrun), 32'd1);
      check_frame("ovr_held", 8'hA0, 16'h0001, 16'h0002);
      @(negedge clk40M);
      check("ovr_clear", 32'(bus.err_overrun), 32'd0);
      check("ovr_count", 32'(n_ovr - base), 32'd1);
      // Accept in the last-byte cycle lets the new frame load directly
      send_seq(80'hA2_05_00_06_00, 5, 4);
      check_frame("ovr_reload", 8'hA2, 16'h0005, 16'h0006);
      check("ovr_reload_nopulse", 32'(bus.err_overrun), 32'd0);
      check("ovr_reload_count", 32'(n_ovr - base), 32'd1);

      // Reset mid-frame while a frame is still held
      base = n_bad;
      send_seq(80'hA1_34_12, 3, -1);
      nRst = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (2) @(negedge clk40M);
      nRst = 1'b1;
      send_spaced(80'hA0_11_22_33_44, 5);
      check_frame("post_reset", 8'hA0, 16'h2211, 16'h4433);
      check("post_reset_nobad", 32'(n_bad - base), 32'd0);
      accept();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
